// File: rtl/memsys_pkg.sv
// memsys_pkg -- shared types and constants for the memsys shared-memory block.
//
// Contents:
//   state_t     controller FSM states (IDLE, WAIT, RESP)
//   port_t      requester identity (INSTR = fetch port, DATA = load/store port)
//   WORD_BYTES  bytes covered by one word index step (word index = addr[..:2])
//   BYTE_OFF_W  number of byte-offset address bits dropped to form the index
//   txn_hdr_t   control part of the transaction register (who, store?, bad address?)
//
// The optional alignment check is selected with the macro MEMSYS_ALIGN_CHK_EN
// in memsys.sv; nothing in this package depends on it.
package memsys_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } port_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_OFF_W = $clog2(WORD_BYTES);

  // Width-independent control fields of the captured transaction. The
  // parameter-sized fields (word index, byte enables, write data) live next to
  // it in the top level because a package type cannot follow module parameters.
  typedef struct packed {
    port_t port;
    logic  we;
    logic  bad;
  } txn_hdr_t;

endpackage : memsys_pkg

// File: rtl/memsys_arb.sv
// memsys_arb -- 2-way round-robin arbiter for memsys.
//
// Ports:
//   req[1:0]    request vector, bit 0 = INSTR port, bit 1 = DATA port
//   last_grant  port that completed the most recent transaction
//   grant[1:0]  one-hot grant (same bit order as req), 0 when nothing requested
//
// Purely combinational; the caller only acts on grant while idle.
module memsys_arb
  import memsys_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Contested: favour whichever port did not win last time.
      2'b11:   grant = (last_grant == INSTR) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule : memsys_arb

// File: rtl/memsys.sv
// memsys -- shared instruction/data memory with req/ready handshakes.
//
// One word-addressed RAM is shared by a fetch port (i_*) and a load/store
// port (d_*). A round-robin arbiter picks one request at a time; the
// transaction then waits WAIT_CYCLES cycles, commits on the edge entering
// RESP, and pulses the owning port's ready for one cycle in RESP.
//
// Ports:
//   clk                     system clock, rising edge
//   reset                   synchronous, active-low reset
//   i_req/i_addr            fetch request and byte address
//   i_rdata/i_ready         fetched word and one-cycle completion pulse
//   d_req/d_we/d_be         data request, store select, per-byte enables
//   d_addr/d_wdata          data byte address and store data
//   d_rdata/d_ready/d_err   load data, completion pulse, alignment error
//   stall                   high while any request is pending or in flight
//
// Build option: define MEMSYS_ALIGN_CHK_EN to flag data accesses whose
// d_addr[1:0] is non-zero (no RAM write, d_rdata cleared, d_err with
// d_ready). Without it d_err is constant 0 and addr[1:0] is ignored.
module memsys
  import memsys_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ready,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                d_err,
  output logic                stall
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int NB    = DATA_W / 8;

  state_t            state_reg, state_next;
  txn_hdr_t          hdr_reg, hdr_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [NB-1:0]     be_reg, be_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [3:0]        cnt_reg, cnt_next;
  port_t             last_grant_reg;

  logic [1:0]        grant;
  logic              bad_addr;
  logic              commit;
  logic [NB-1:0]     lane_we;

  logic [DATA_W-1:0] ram [DEPTH_WORDS];
  logic [DATA_W-1:0] i_rdata_reg, d_rdata_reg;

  // Upper address bits wrap and the byte offset is not otherwise decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr, d_addr};

`ifdef MEMSYS_ALIGN_CHK_EN
  assign bad_addr = (d_addr[BYTE_OFF_W-1:0] != '0);
`else
  assign bad_addr = 1'b0;
`endif

  memsys_arb u_arb (
    .req        ({d_req, i_req}),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      hdr_reg.port   <= INSTR;
      hdr_reg.we     <= 1'b0;
      hdr_reg.bad    <= 1'b0;
      idx_reg        <= '0;
      be_reg         <= '0;
      wdata_reg      <= '0;
      cnt_reg        <= '0;
      last_grant_reg <= INSTR;
    end else begin
      state_reg <= state_next;
      hdr_reg   <= hdr_next;
      idx_reg   <= idx_next;
      be_reg    <= be_next;
      wdata_reg <= wdata_next;
      cnt_reg   <= cnt_next;
      if (state_reg == RESP) begin
        last_grant_reg <= hdr_reg.port;
      end
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    hdr_next   = hdr_reg;
    idx_next   = idx_reg;
    be_next    = be_reg;
    wdata_next = wdata_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (grant != 2'b00) begin
          hdr_next.port = grant[1] ? DATA : INSTR;
          hdr_next.we   = grant[1] & d_we;
          hdr_next.bad  = grant[1] & bad_addr;
          idx_next      = grant[1] ? d_addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W]
                                   : i_addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
          be_next       = grant[1] ? d_be : '0;
          wdata_next    = d_wdata;
          cnt_next      = 4'(WAIT_CYCLES);
          state_next    = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    i_ready = 1'b0;
    d_ready = 1'b0;
    d_err   = 1'b0;
    if (state_reg == RESP) begin
      if (hdr_reg.port == DATA) begin
        d_ready = 1'b1;
`ifdef MEMSYS_ALIGN_CHK_EN
        d_err   = hdr_reg.bad;
`endif
      end else begin
        i_ready = 1'b1;
      end
    end
  end

  assign stall = i_req | d_req | (state_reg != IDLE);

  // The access commits on the edge that enters RESP. The *_next view is used
  // so that a zero-wait transaction (captured on this same edge) commits too;
  // in WAIT the *_next fields simply equal the captured register.
  assign commit = reset & (state_next == RESP);

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign lane_we[gi] = commit & hdr_next.we & ~hdr_next.bad & be_next[gi];
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (lane_we[b]) begin
        ram[idx_next][8*b +: 8] <= wdata_next[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
    end else if (commit) begin
      if (hdr_next.port == DATA) begin
        if (hdr_next.bad) begin
          d_rdata_reg <= '0;
        end else if (!hdr_next.we) begin
          d_rdata_reg <= ram[idx_next];
        end
      end else begin
        i_rdata_reg <= ram[idx_next];
      end
    end
  end

  assign i_rdata = i_rdata_reg;
  assign d_rdata = d_rdata_reg;

endmodule : memsys

// File: tb/tb_memsys.sv
// tb_memsys -- directed self-checking bench for memsys.
// Instance dut uses WAIT_CYCLES=1; instance dut3 uses WAIT_CYCLES=3 for the
// reset-during-transaction case. Inputs change and outputs are sampled on the
// falling clock edge. Build with +define+MEMSYS_ALIGN_CHK_EN to exercise the
// alignment-check variant.
module tb_memsys;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // dut (WAIT_CYCLES = 1)
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_err;
  logic        stall;

  // dut3 (WAIT_CYCLES = 3)
  logic        r_i_req = 1'b0;
  logic [31:0] r_i_addr = '0;
  logic [31:0] r_i_rdata;
  logic        r_i_ready;
  logic        r_d_req = 1'b0;
  logic        r_d_we = 1'b0;
  logic [3:0]  r_d_be = '0;
  logic [31:0] r_d_addr = '0;
  logic [31:0] r_d_wdata = '0;
  logic [31:0] r_d_rdata;
  logic        r_d_ready;
  logic        r_d_err;
  logic        r_stall;

  int n_checks = 0;
  int n_fail   = 0;

  memsys #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err), .stall(stall)
  );

  memsys #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset),
    .i_req(r_i_req), .i_addr(r_i_addr), .i_rdata(r_i_rdata), .i_ready(r_i_ready),
    .d_req(r_d_req), .d_we(r_d_we), .d_be(r_d_be), .d_addr(r_d_addr), .d_wdata(r_d_wdata),
    .d_rdata(r_d_rdata), .d_ready(r_d_ready), .d_err(r_d_err), .stall(r_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One data access on dut; lat = falling edges from request to ready (-1 on timeout).
  task automatic d_access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat);
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
    lat = -1; rdata = '0; err = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (d_ready) begin
        lat = c; rdata = d_rdata; err = d_err;
        break;
      end
    end
    d_req = 1'b0; d_we = 1'b0; d_be = '0;
    $display("txn dut  d we=%0d be=%h addr=%08h wdata=%08h rdata=%08h err=%0d lat=%0d",
             we, be, addr, wdata, rdata, err, lat);
  endtask

  task automatic i_fetch(input logic [31:0] addr, output logic [31:0] rdata, output int lat);
    @(negedge clk);
    i_req = 1'b1; i_addr = addr;
    lat = -1; rdata = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (i_ready) begin
        lat = c; rdata = i_rdata;
        break;
      end
    end
    i_req = 1'b0;
    $display("txn dut  i addr=%08h rdata=%08h lat=%0d", addr, rdata, lat);
  endtask

  task automatic r_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat);
    @(negedge clk);
    r_d_req = 1'b1; r_d_we = we; r_d_be = 4'hF; r_d_addr = addr; r_d_wdata = wdata;
    lat = -1; rdata = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (r_d_ready) begin
        lat = c; rdata = r_d_rdata;
        break;
      end
    end
    r_d_req = 1'b0; r_d_we = 1'b0;
    $display("txn dut3 d we=%0d addr=%08h wdata=%08h rdata=%08h lat=%0d",
             we, addr, wdata, rdata, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nseen;
    logic [3:0]  order;
    logic        overlap, stall_low, ready_seen;

    // ---- reset state ----
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_i_ready", 32'(i_ready), 32'd0);
    check("rst_d_ready", 32'(d_ready), 32'd0);
    check("rst_d_err",   32'(d_err),   32'd0);
    check("rst_i_rdata", i_rdata,      32'd0);
    check("rst_d_rdata", d_rdata,      32'd0);
    check("rst_stall",   32'(stall),   32'd0);
    reset = 1'b1;

    // ---- store then load, ready 2 cycles after accept ----
    d_access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("st10_lat", 32'(lat), 32'd2);
    d_access(1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
    check("ld10_lat",  32'(lat), 32'd2);
    check("ld10_data", rd, 32'hDEADBEEF);
    check("ld10_err",  32'(er), 32'd0);
    check("ld10_i_rdata_kept", i_rdata, 32'd0);

    // ---- byte enables ----
    d_access(1'b1, 4'hF,    32'h20, 32'h11223344, rd, er, lat);
    d_access(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, rd, er, lat);
    d_access(1'b0, 4'h0,    32'h20, 32'h0, rd, er, lat);
    check("be_merge", rd, 32'h11BB33DD);

    // ---- store with no byte enables leaves the word alone ----
    d_access(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, rd, er, lat);
    check("be0_lat", 32'(lat), 32'd2);
    d_access(1'b0, 4'h0, 32'h20, 32'h0, rd, er, lat);
    check("be0_data", rd, 32'h11BB33DD);

    // ---- address wrap: 0x400 aliases word 0 ----
    d_access(1'b1, 4'hF, 32'h400, 32'hCAFEF00D, rd, er, lat);
    i_fetch(32'h0, rd, lat);
    check("wrap_lat",  32'(lat), 32'd2);
    check("wrap_data", rd, 32'hCAFEF00D);
    check("wrap_d_rdata_kept", d_rdata, 32'h11BB33DD);

    // ---- contention from reset: DATA, INSTR, DATA, INSTR ----
    @(negedge clk);
    reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h10;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    nseen = 0; order = '0; overlap = 1'b0; stall_low = 1'b0;
    for (int c = 0; c < 40 && nseen < 4; c++) begin
      @(negedge clk);
      if (!stall) stall_low = 1'b1;
      if (i_ready && d_ready) overlap = 1'b1;
      if (i_ready || d_ready) begin
        order[3-nseen] = d_ready;
        $display("txn dut  contention grant %0d -> %s", nseen, d_ready ? "DATA" : "INSTR");
        nseen++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    check("cont_count",   32'(nseen), 32'd4);
    check("cont_order",   32'(order), 32'b1010);
    check("cont_overlap", 32'(overlap), 32'd0);
    check("cont_stall",   32'(stall_low), 32'd0);
    check("cont_i_rdata", i_rdata, 32'hCAFEF00D);
    check("cont_d_rdata", d_rdata, 32'hDEADBEEF);

    // ---- reset during a WAIT_CYCLES=3 store ----
    r_access(1'b1, 32'h30, 32'h12345678, rd, lat);
    check("r_st_lat", 32'(lat), 32'd4);
    @(negedge clk);
    r_d_req = 1'b1; r_d_we = 1'b1; r_d_be = 4'hF; r_d_addr = 32'h30; r_d_wdata = 32'h55;
    @(negedge clk);                       // accept edge has passed
    ready_seen = r_d_ready;
    reset = 1'b0; r_d_req = 1'b0; r_d_we = 1'b0;
    @(negedge clk);                       // one edge with reset low
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (r_d_ready) ready_seen = 1'b1;
    end
    $display("txn dut3 d aborted store addr=00000030 wdata=00000055 ready_seen=%0d", ready_seen);
    check("abort_no_ready", 32'(ready_seen), 32'd0);
    check("abort_stall",    32'(r_stall), 32'd0);
    r_access(1'b0, 32'h30, 32'h0, rd, lat);
    check("abort_ld_data", rd, 32'h12345678);

    // ---- alignment ----
    d_access(1'b1, 4'hF, 32'h22, 32'hFFFFFFFF, rd, er, lat);
    check("align_lat", 32'(lat), 32'd2);
`ifdef MEMSYS_ALIGN_CHK_EN
    check("align_err",   32'(er), 32'd1);
    check("align_rdata", rd, 32'd0);
    d_access(1'b0, 4'h0, 32'h20, 32'h0, rd, er, lat);
    check("align_ld_data", rd, 32'h11BB33DD);
    check("align_ld_err",  32'(er), 32'd0);
`else
    check("align_err", 32'(er), 32'd0);
    d_access(1'b0, 4'h0, 32'h20, 32'h0, rd, er, lat);
    check("align_ld_data", rd, 32'hFFFFFFFF);
    check("align_ld_err",  32'(er), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_memsys

// File: doc/memsys.md
Name: memsys

Overview:
- Parametrised shared-memory subsystem; the next-generation replacement for separate single-cycle instruction and data memories in the computer top.
- One word-addressed RAM serves an instruction-fetch port and a data load/store port.
- Each port uses a req/ready handshake, with configurable wait states and per-byte write enables.
- A 2-way round-robin arbiter serialises access; `stall` tells the cpu to freeze.

Parameters:
- DATA_W, 32: word width in bits; must be a multiple of 8.
- ADDR_W, 32: byte-address width on both ports.
- DEPTH_WORDS, 256: RAM depth in words; power of 2.
- WAIT_CYCLES, 1: extra cycles between accept and ready; range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge).
- i_req  in  1  instruction fetch request; held until i_ready.
- i_addr  in  ADDR_W  fetch byte address.
- i_rdata  out  DATA_W  fetched word; valid when i_ready==1.
- i_ready  out  1  one-cycle completion pulse for the fetch port.
- d_req  in  1  data access request; held until d_ready.
- d_we  in  1  1=store, 0=load.
- d_be  in  DATA_W/8  byte enables for a store (bit k -> byte k).
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid when d_ready==1.
- d_ready  out  1  one-cycle completion pulse for the data port.
- d_err  out  1  alignment error flag; 0 unless MEMSYS_ALIGN_CHK_EN.
- stall  out  1  1 while any request is pending or in flight.

Behaviour:
- Reset values:
  - state=IDLE, i_ready=0, d_ready=0, d_err=0.
  - i_rdata=0, d_rdata=0, wait counter=0.
  - last_grant=INSTR, so the first contested grant goes to DATA.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If neither req is high: stay in IDLE.
  - If one req is high: grant that port.
  - If both are high: grant the port not in last_grant.
  - On a grant: latch port id, word index, we, be, wdata into the transaction register, and load counter=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
- WAIT: decrement the counter each cycle; when it reaches 1, the next state is RESP.
- Access commit happens on the clock edge entering RESP:
  - Store: RAM[idx] byte k <= wdata byte k for every be[k]==1.
  - Load or fetch: the granted rdata register <= RAM[idx].
- RESP:
  - The granted port's ready=1 for exactly this one cycle; update last_grant.
  - Next state is IDLE; a new grant is possible on the following cycle.
- Latency from the accept edge to ready high is WAIT_CYCLES+1 cycles. Throughput is one transaction per WAIT_CYCLES+2 cycles.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo the RAM size.
- A store with d_be==0 completes normally with no RAM change.
- rdata registers hold their last value between transactions; the non-granted port's rdata is unchanged.
- A req dropped after grant does not abort the transaction; it completes and ready still pulses.
- stall = i_req | d_req | (state!=IDLE).
- Reset asserted mid-transaction: the FSM returns to IDLE and no ready pulse is produced. A store not yet committed (still in IDLE/WAIT) is discarded.

Optional Feature:
- Macro: MEMSYS_ALIGN_CHK_EN.
- Defined: a data access with d_addr[1:0]!=0 is granted normally, but at the commit edge:
  - no RAM write occurs;
  - d_rdata <= 0;
  - d_err=1 for the same RESP cycle as d_ready.
  - Fetches are not checked.
- Undefined: d_err is tied 0, and addr[1:0] is ignored on both ports.

Decomposition:
- memsys_pkg holds:
  - state_t enum (IDLE, WAIT, RESP);
  - port_t enum (INSTR, DATA);
  - WORD_BYTES constant;
  - the transaction-register struct type.
- One sub-module: memsys_arb, a 2-way round-robin arbiter (req[1:0], last_grant -> grant one-hot).

Test Plan:
- Reset, then a single store and load, WAIT_CYCLES=1:
  - Stimulus: store d_addr=0x10, d_wdata=0xDEADBEEF, d_be=4'hF; then load 0x10.
  - Required: each d_ready arrives 2 cycles after accept, and the load returns d_rdata=0xDEADBEEF.
- Byte enables:
  - Stimulus: store 0x11223344 to 0x20 with be=4'hF, then store 0xAABBCCDD with be=4'b0101, then load.
  - Required: the load returns 0x11BB33DD.
- Contention: i_req and d_req both held continuously from reset.
  - Required: grants go DATA, INSTR, DATA, INSTR.
  - Required: stall stays 1 throughout; i_ready and d_ready are never high together.
- Wrap-around with DEPTH_WORDS=256:
  - Stimulus: store 0xCAFEF00D to 0x400, then fetch i_addr=0x000.
  - Required: i_rdata=0xCAFEF00D.
- Reset mid-transaction:
  - Stimulus: store 0x55 to 0x30 with WAIT_CYCLES=3; pull reset low 1 cycle after accept; after reset, load 0x30.
  - Required: no d_ready from the aborted store; the load returns the pre-store value.
- Alignment check, with MEMSYS_ALIGN_CHK_EN defined:
  - Stimulus: store to 0x22.
  - Required: d_ready=1 with d_err=1; a subsequent load of 0x20 is unchanged.
  - Required without the macro: d_err stays 0.
